// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. The merged word and
// its completion flag are presented combinationally in the cycle the last
// lane is accepted so the parent can register the memory write directly.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      asm_q, asm_d;
  logic [31:0]      merged;

  // Insert the incoming byte into its lane and advance the lane index.
  always_comb begin
    merged = asm_q;
    case (idx_q)
      2'd0:    merged[7:0]   = byte_data;
      2'd1:    merged[15:8]  = byte_data;
      2'd2:    merged[23:16] = byte_data;
      default: merged[31:24] = byte_data;
    endcase

    asm_d = asm_q;
    idx_d = idx_q;
    if (clear) begin
      asm_d = '0;
      idx_d = '0;
    end else if (byte_valid) begin
      asm_d = merged;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  assign word_valid = byte_valid && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word       = merged;

  // Lane storage and index, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed, XOR
// checksummed byte frame, writes packed words to sequential addresses and
// releases the core only after a fully verified load.
//
// state  | meaning
// IDLE   | after reset, core held, waiting for start
// LEN_LO | expecting low byte of word count
// LEN_HI | expecting high byte of word count, range-checked
// DATA   | receiving payload, one memory write per 4 bytes
// CSUM   | expecting checksum byte
// DONE   | load verified, core released
// ERROR  | length or checksum failure, core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [LEN_WIDTH:0] MAX_N = (LEN_WIDTH + 1)'(MAX_WORDS);

  state_t                state_q;
  logic                  rx_ready_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic                  core_hold_q;
  logic                  load_done_q;
  logic                  load_error_q;

  logic [7:0]            len_lo_q;
  logic [LEN_WIDTH-1:0]  words_left_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic [7:0]            csum_q;

  logic                  byte_acc;
  logic                  load_start;
  logic                  asm_byte_valid;
  logic                  asm_word_valid;
  logic [31:0]           asm_word;
  logic [LEN_WIDTH-1:0]  len_n;

  assign byte_acc       = rx_valid && rx_ready_q;
  assign load_start     = start && ((state_q == IDLE) || (state_q == DONE) ||
                                    (state_q == ERROR));
  assign asm_byte_valid = byte_acc && (state_q == DATA);
  assign len_n          = {rx_data, len_lo_q};

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_valid (asm_byte_valid),
    .byte_data  (rx_data),
    .word_valid (asm_word_valid),
    .word       (asm_word)
  );

  // Frame FSM with counters, checksum and registered outputs; the write
  // registers are separate from the assembler so a byte can be accepted in
  // the same cycle the previous word is being written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      len_lo_q     <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_q      <= LEN_LO;
            rx_ready_q   <= 1'b1;
            core_hold_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            len_lo_q     <= '0;
            words_left_q <= '0;
            word_idx_q   <= '0;
            csum_q       <= '0;
          end
        end
        LEN_LO: begin
          if (byte_acc) begin
            len_lo_q <= rx_data;
            state_q  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (byte_acc) begin
            if ({1'b0, len_n} > MAX_N) begin
              state_q      <= ERROR;
              rx_ready_q   <= 1'b0;
              load_error_q <= 1'b1;
            end else if (len_n == '0) begin
              state_q <= CSUM;
            end else begin
              state_q      <= DATA;
              words_left_q <= len_n;
            end
          end
        end
        DATA: begin
          if (byte_acc) begin
            csum_q <= csum_q ^ rx_data;
            if (asm_word_valid) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= word_idx_q;
              imem_wdata_q <= asm_word;
              words_left_q <= words_left_q - LEN_WIDTH'(1);
              // Index stops at the last word so it never passes N-1.
              if (words_left_q == LEN_WIDTH'(1)) begin
                state_q <= CSUM;
              end else begin
                word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
              end
            end
          end
        end
        CSUM: begin
          if (byte_acc) begin
            rx_ready_q <= 1'b0;
            if (rx_data == csum_q) begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
              core_hold_q <= 1'b0;
            end else begin
              state_q      <= ERROR;
              load_error_q <= 1'b1;
              core_hold_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame vectors from a table, a write scoreboard
// fed by a frame model, and hand sequences for reset and error corners.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  imem_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b[16];
    int         n;
    int         gap;
    bit         mid_start;
    logic       done;
    logic       err;
    logic       hold;
    int         writes;
  } vec_t;

  vec_t        vec[5];
  logic [39:0] exp_q[$];
  logic [39:0] mon_e;
  logic [31:0] shadow[256];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_cnt   = 0;
  logic [7:0]  last_addr;
  logic [31:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, got no response, expected handshake", name);
  endtask

  // Scoreboard: every write strobe must match the next modelled write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", {24'h0, imem_addr}, {24'h0, mon_e[39:32]});
        chk("write_data", imem_wdata, mon_e[31:0]);
      end
      shadow[imem_addr] = imem_wdata;
      wr_cnt++;
    end
  end

  // Frame model: push every complete payload word the first n bytes carry.
  task automatic model_push(input int vi, input int n);
    int len;
    len = int'({vec[vi].b[1], vec[vi].b[0]});
    if (len <= 256) begin
      for (int w = 0; w < len; w++) begin
        if (5 + 4 * w < n) begin
          last_addr = 8'(w);
          last_data = {vec[vi].b[5+4*w], vec[vi].b[4+4*w], vec[vi].b[3+4*w], vec[vi].b[2+4*w]};
          exp_q.push_back({last_addr, last_data});
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      fail_now("rx_accept_timeout");
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int vi);
    int wr_before;
    wr_before = wr_cnt;
    model_push(vi, vec[vi].n);
    pulse_start();
    chk("start_core_hold", core_hold, 1'b1);
    chk("start_done_clr", load_done, 1'b0);
    chk("start_err_clr", load_error, 1'b0);
    chk("start_rx_ready", rx_ready, 1'b1);
    for (int k = 0; k < vec[vi].n; k++) begin
      send_byte(vec[vi].b[k], vec[vi].gap);
      if (vec[vi].mid_start && k == 3) pulse_start();
    end
    repeat (3) @(negedge clk);
    chk("load_done", load_done, vec[vi].done);
    chk("load_error", load_error, vec[vi].err);
    chk("core_hold", core_hold, vec[vi].hold);
    chk("rx_ready_end", rx_ready, 1'b0);
    chk("write_count", wr_cnt - wr_before, vec[vi].writes);
    chk("queue_drained", exp_q.size(), 0);
    if (vec[vi].writes > 0) begin
      chk("addr_hold", {24'h0, imem_addr}, {24'h0, last_addr});
      chk("wdata_hold", imem_wdata, last_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0].b = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05,
                 8'h20, 8'h00, 8'hB0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[0].n = 11; vec[0].gap = 0; vec[0].mid_start = 1'b0;
    vec[0].done = 1'b1; vec[0].err = 1'b0; vec[0].hold = 1'b0; vec[0].writes = 2;

    vec[1].b = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05,
                 8'h20, 8'h00, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[1].n = 11; vec[1].gap = 0; vec[1].mid_start = 1'b0;
    vec[1].done = 1'b0; vec[1].err = 1'b1; vec[1].hold = 1'b1; vec[1].writes = 2;

    vec[2].b = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[2].n = 2; vec[2].gap = 0; vec[2].mid_start = 1'b0;
    vec[2].done = 1'b0; vec[2].err = 1'b1; vec[2].hold = 1'b1; vec[2].writes = 0;

    vec[3].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[3].n = 3; vec[3].gap = 3; vec[3].mid_start = 1'b0;
    vec[3].done = 1'b1; vec[3].err = 1'b0; vec[3].hold = 1'b0; vec[3].writes = 0;

    vec[4].b = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[4].n = 7; vec[4].gap = 2; vec[4].mid_start = 1'b1;
    vec[4].done = 1'b1; vec[4].err = 1'b0; vec[4].hold = 1'b0; vec[4].writes = 1;

    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_imem_addr", {24'h0, imem_addr}, 32'h0);
    chk("rst_imem_wdata", imem_wdata, 32'h0);
    chk("rst_core_hold", core_hold, 1'b1);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_load_error", load_error, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_vec(i);
      if (i == 0) begin
        chk("mem0_normal", shadow[0], 32'h00100513);
        chk("mem1_normal", shadow[1], 32'h00200593);
      end
      if (i == 2) begin
        // Over-length frame: ERROR must refuse any further bytes.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (5) begin
          @(negedge clk);
          chk("error_refuses_bytes", rx_ready, 1'b0);
        end
        rx_valid = 1'b0;
        chk("error_no_write", imem_we, 1'b0);
      end
      if (i == 4) chk("mem0_overwritten", shadow[0], 32'hDDCCBBAA);
    end

    // Reset mid-load after five payload bytes: one write, then reset state.
    begin
      int wr_before;
      wr_before = wr_cnt;
      model_push(0, 7);
      pulse_start();
      for (int k = 0; k < 7; k++) send_byte(vec[0].b[k], 0);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_rx_ready", rx_ready, 1'b0);
      chk("midrst_imem_we", imem_we, 1'b0);
      chk("midrst_imem_addr", {24'h0, imem_addr}, 32'h0);
      chk("midrst_imem_wdata", imem_wdata, 32'h0);
      chk("midrst_core_hold", core_hold, 1'b1);
      chk("midrst_load_done", load_done, 1'b0);
      chk("midrst_load_error", load_error, 1'b0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_write_count", wr_cnt - wr_before, 1);
      chk("midrst_queue", exp_q.size(), 0);
      chk("midrst_mem0", shadow[0], 32'h00100513);
    end

    // Full frame after the aborted one loads from address 0 again.
    run_vec(0);
    chk("reload_mem0", shadow[0], 32'h00100513);
    chk("reload_mem1", shadow[1], 32'h00200593);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
